// File: rtl/match_keeper_if.sv
// Control and display bundle between the goal detection logic and match_keeper.
// The master side drives match requests and goals; the slave side reports match status.
interface match_keeper_if #(
    parameter int SEC_W   = 8,
    parameter int SCORE_W = 3
);
    logic               start;
    logic               pause;
    logic               goal_p1;
    logic               goal_p2;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    logic [SEC_W-1:0]   secs_left;
    logic               sec_tick;
    logic [1:0]         state;
    logic [1:0]         winner;

    modport master (
        output start, pause, goal_p1, goal_p2,
        input  score_p1, score_p2, secs_left, sec_tick, state, winner
    );

    modport slave (
        input  start, pause, goal_p1, goal_p2,
        output score_p1, score_p2, secs_left, sec_tick, state, winner
    );
endinterface

// File: rtl/match_keeper.sv
// Air-hockey match controller: two saturating score counters, a prescaled
// seconds countdown and the IDLE/RUN/PAUSED/OVER match FSM with winner report.
module match_keeper #(
    parameter int CLK_HZ     = 50000000,
    parameter int MATCH_SECS = 150,
    parameter int SEC_W      = 8,
    parameter int SCORE_W    = 3,
    parameter int WIN_SCORE  = 7
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear,
    match_keeper_if.slave mk
);

    localparam int                 PW        = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0]      PRESC_MAX = PW'(CLK_HZ - 1);
    localparam logic [SEC_W-1:0]   SECS_INIT = SEC_W'(MATCH_SECS);
    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10,
        ST_OVER   = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [SCORE_W-1:0] score2_q, score2_d;
    logic [SEC_W-1:0]   secs_q, secs_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic               tick_q, tick_d;
    logic [1:0]         winner_q, winner_d;

    logic [SCORE_W-1:0] s1_post, s2_post;
    logic [SEC_W-1:0]   secs_dec;
    logic               wrap;

    // Scores stop at the win score so a late goal can never wrap the counter.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                   input logic               goal);
        if (goal && (s != WIN)) begin
            return s + SCORE_W'(1);
        end
        return s;
    endfunction

    function automatic logic [1:0] timeout_winner(input logic [SCORE_W-1:0] s1,
                                                  input logic [SCORE_W-1:0] s2);
        if (s1 > s2) begin
            return 2'b01;
        end
        if (s2 > s1) begin
            return 2'b10;
        end
        return 2'b11;
    endfunction

    assign s1_post  = sat_inc(score1_q, mk.goal_p1);
    assign s2_post  = sat_inc(score2_q, mk.goal_p2);
    assign secs_dec = secs_q - SEC_W'(1);
    assign wrap     = (presc_q == PRESC_MAX);

    always_comb begin
        state_d  = state_q;
        score1_d = score1_q;
        score2_d = score2_q;
        secs_d   = secs_q;
        presc_d  = presc_q;
        tick_d   = 1'b0;
        winner_d = winner_q;

        if (clear) begin
            state_d  = ST_IDLE;
            score1_d = '0;
            score2_d = '0;
            secs_d   = SECS_INIT;
            presc_d  = '0;
            winner_d = 2'b00;
        end else begin
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (mk.start) begin
                        state_d  = ST_RUN;
                        score1_d = '0;
                        score2_d = '0;
                        secs_d   = SECS_INIT;
                        presc_d  = '0;
                        winner_d = 2'b00;
                    end
                end
                ST_RUN: begin
                    if (mk.pause) begin
                        state_d = ST_PAUSED;
                    end else begin
                        score1_d = s1_post;
                        score2_d = s2_post;
                        if (wrap) begin
                            presc_d = '0;
                            secs_d  = secs_dec;
                            tick_d  = 1'b1;
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                        // A win score outranks expiry on the same edge.
                        if ((s1_post == WIN) || (s2_post == WIN)) begin
                            state_d  = ST_OVER;
                            winner_d = {s2_post == WIN, s1_post == WIN};
                        end else if (wrap && (secs_dec == '0)) begin
                            state_d  = ST_OVER;
                            winner_d = timeout_winner(s1_post, s2_post);
                        end
                    end
                end
                ST_PAUSED: begin
                    if (!mk.pause) begin
                        state_d = ST_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            score1_q <= '0;
            score2_q <= '0;
            secs_q   <= SECS_INIT;
            presc_q  <= '0;
            tick_q   <= 1'b0;
            winner_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            secs_q   <= secs_d;
            presc_q  <= presc_d;
            tick_q   <= tick_d;
            winner_q <= winner_d;
        end
    end

    assign mk.score_p1  = score1_q;
    assign mk.score_p2  = score2_q;
    assign mk.secs_left = secs_q;
    assign mk.sec_tick  = tick_q;
    assign mk.state     = state_q;
    assign mk.winner    = winner_q;

endmodule
